s1_serial_tx: RTL and testbench

Serial transmitter stage that feeds the S2 receiver. After reset it reads all eight 18-bit words from register bank RB1 and sends each as a 21-bit serial frame on `sen`/`sd`: 3-bit word address first, then 18 data bits, MSB first. Frames are separated by idle gaps so the receiver can store each word. When the last frame is sent, `S1_done` rises and stays high.

---
 rtl/s1_serial_tx.sv | 143 ++++++++++++++
 tb/tb_s1_serial_tx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/s1_serial_tx.sv
// rtl/s1_serial_tx.sv - RB1 reader and serial frame transmitter feeding the S2 receiver
//
// After reset, reads every RB1 word in address order and sends each one as a
// serial frame: ADDR_WIDTH address bits, then WORD_WIDTH data bits, MSB first.
// Frames are separated by idle gaps so the receiver can store each word.
//
// Ports:
//   clk      - single clock, rising edge
//   rst      - asynchronous active-high reset
//   RB1_RW   - RB1 read/write select, held at 1 (read)
//   RB1_A    - RB1 word address, presented while in READ
//   RB1_D    - RB1 write data, held at 0
//   RB1_Q    - RB1 read data, valid the cycle after RB1_A
//   sen      - serial enable, active-low while frame bits are driven
//   sd       - serial data
//   S1_done  - high once every frame has been sent

module s1_serial_tx #(
    parameter int WORD_WIDTH = 18,
    parameter int ADDR_WIDTH = 3,
    parameter int WORD_DEPTH = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  RB1_RW,
    output logic [ADDR_WIDTH-1:0] RB1_A,
    output logic [WORD_WIDTH-1:0] RB1_D,
    input  logic [WORD_WIDTH-1:0] RB1_Q,
    output logic                  sen,
    output logic                  sd,
    output logic                  S1_done
);

    localparam int FRAME_W = ADDR_WIDTH + WORD_WIDTH;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam int GAP_W   = $clog2(GAP_CYCLES + 1);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(WORD_DEPTH - 1);
    localparam logic [CNT_W-1:0]      LAST_BIT = CNT_W'(FRAME_W - 1);
    localparam logic [GAP_W-1:0]      LAST_GAP = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        SEND,
        GAP,
        DONE
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   word_idx;
    logic [CNT_W-1:0]        bit_cnt;
    logic [GAP_W-1:0]        gap_cnt;
    // Bits of the current frame still waiting to be driven; MSB is the next bit.
    logic [FRAME_W-1:0]      shreg;
    logic [FRAME_W-1:0]      frame;

    assign frame = {word_idx, RB1_Q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            word_idx <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            shreg    <= '0;
            RB1_RW   <= 1'b1;
            RB1_A    <= '0;
            RB1_D    <= '0;
            sen      <= 1'b1;
            sd       <= 1'b0;
            S1_done  <= 1'b0;
        end else begin
            RB1_RW <= 1'b1;
            RB1_D  <= '0;
            case (state)
                IDLE: begin
                    RB1_A <= word_idx;
                    state <= READ;
                end

                // RB1 registers the address at the end of this cycle; its data
                // is on RB1_Q throughout LATCH.
                READ: begin
                    state <= LATCH;
                end

                // The first frame bit is registered here so sen falls exactly
                // when the frame starts; the remainder waits in shreg.
                LATCH: begin
                    sd      <= frame[FRAME_W-1];
                    shreg   <= {frame[FRAME_W-2:0], 1'b0};
                    sen     <= 1'b0;
                    bit_cnt <= '0;
                    state   <= SEND;
                end

                SEND: begin
                    if (bit_cnt == LAST_BIT) begin
                        sen     <= 1'b1;
                        sd      <= 1'b0;
                        gap_cnt <= '0;
                        state   <= GAP;
                    end else begin
                        sd      <= shreg[FRAME_W-1];
                        shreg   <= {shreg[FRAME_W-2:0], 1'b0};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                GAP: begin
                    if (gap_cnt == LAST_GAP) begin
                        // Index is compared against the last word before any
                        // increment, so it never wraps.
                        if (word_idx == LAST_IDX) begin
                            S1_done <= 1'b1;
                            state   <= DONE;
                        end else begin
                            word_idx <= word_idx + 1'b1;
                            RB1_A    <= word_idx + 1'b1;
                            state    <= READ;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                DONE: begin
                    S1_done <= 1'b1;
                    sen     <= 1'b1;
                    sd      <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_s1_serial_tx.sv
// tb/tb_s1_serial_tx.sv - self-checking bench for s1_serial_tx with RB1/S2 models
module tb_s1_serial_tx;

    localparam int NCYC = 216;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rb1_rw;
    logic [2:0]  rb1_a;
    logic [17:0] rb1_d;
    logic [17:0] rb1_q;
    logic        sen;
    logic        sd;
    logic        s1_done;

    always #5 clk = ~clk;

    s1_serial_tx dut (
        .clk     (clk),
        .rst     (rst),
        .RB1_RW  (rb1_rw),
        .RB1_A   (rb1_a),
        .RB1_D   (rb1_d),
        .RB1_Q   (rb1_q),
        .sen     (sen),
        .sd      (sd),
        .S1_done (s1_done)
    );

    logic [17:0] rb1_mem [8];
    logic [17:0] rb2_mem [8];
    logic [20:0] exp_frame [8];

    always @(posedge clk) rb1_q <= rb1_mem[rb1_a];

    logic [20:0] rx_sh = '0;
    int          rx_cnt = 0;
    always @(negedge clk) begin
        if (sen === 1'b0) begin
            rx_sh  = {rx_sh[19:0], sd};
            rx_cnt = rx_cnt + 1;
        end else begin
            if (rx_cnt == 21) rb2_mem[rx_sh[20:18]] = rx_sh[17:0];
            rx_cnt = 0;
        end
    end

    logic       sen_log  [NCYC];
    logic       sd_log   [NCYC];
    logic       done_log [NCYC];
    logic [2:0] a_log    [NCYC];
    int         rwd_bad;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic record(input int c);
        sen_log[c]  = sen;
        sd_log[c]   = sd;
        done_log[c] = s1_done;
        a_log[c]    = rb1_a;
        if (rb1_rw !== 1'b1 || rb1_d !== 18'h0) rwd_bad++;
    endtask

    task automatic load(input string kind);
        for (int k = 0; k < 8; k++) begin
            case (kind)
                "inc":   rb1_mem[k] = 18'h01000 + 18'(k);
                "w5":    rb1_mem[k] = (k == 5) ? 18'h3FFFF : 18'h0;
                default: rb1_mem[k] = (k % 2 == 0) ? 18'h2AAAA : 18'h15555;
            endcase
            exp_frame[k] = {3'(k), rb1_mem[k]};
            rb2_mem[k]   = 18'h1CCCC;
        end
    endtask

    // Release reset at a negedge; cycle c is sampled at the negedge after edge c-1.
    task automatic run(input string name, input int abort_cyc);
        rwd_bad = 0;
        @(negedge clk);
        rst = 1'b0;
        record(0);
        for (int c = 1; c < NCYC; c++) begin
            @(negedge clk);
            record(c);
            if (c == abort_cyc) begin
                check({name, "/pre_abort_sen"}, 32'(sen_log[c]), 32'd0);
                check({name, "/pre_abort_sd"}, 32'(sd_log[c]), 32'(exp_frame[3][10]));
                rst = 1'b1;
                #1;
                check({name, "/async_sen"}, 32'(sen), 32'd1);
                check({name, "/async_sd"}, 32'(sd), 32'd0);
                check({name, "/async_a"}, 32'(rb1_a), 32'd0);
                @(posedge clk);
                @(posedge clk);
                return;
            end
        end
    endtask

    task automatic analyze(input string name);
        int          bad;
        logic [20:0] frm;
        bad = 0;
        for (int c = 0; c < NCYC; c++) begin
            logic exp_low;
            exp_low = (c >= 3) && (((c - 3) % 25) <= 20) && (((c - 3) / 25) < 8);
            if (sen_log[c] !== !exp_low) bad++;
        end
        check({name, "/sen_pattern"}, 32'(bad), 32'd0);
        bad = 0;
        for (int c = 0; c < NCYC; c++)
            if (sen_log[c] === 1'b1 && sd_log[c] !== 1'b0) bad++;
        check({name, "/sd_idle"}, 32'(bad), 32'd0);
        check({name, "/rw_d"}, 32'(rwd_bad), 32'd0);
        for (int n = 0; n < 8; n++) begin
            check($sformatf("%s/rb1_a%0d", name, n), 32'(a_log[1 + 25 * n]), 32'(n));
            frm = '0;
            for (int b = 0; b < 21; b++) frm = {frm[19:0], sd_log[3 + 25 * n + b]};
            check($sformatf("%s/frame%0d", name, n), 32'(frm), 32'(exp_frame[n]));
            check($sformatf("%s/rb2_%0d", name, n), 32'(rb2_mem[n]), 32'(rb1_mem[n]));
        end
        check({name, "/done_200"}, 32'(done_log[200]), 32'd0);
        check({name, "/done_201"}, 32'(done_log[201]), 32'd1);
        bad = 0;
        for (int c = 201; c < NCYC; c++) if (done_log[c] !== 1'b1) bad++;
        check({name, "/done_hold"}, 32'(bad), 32'd0);
    endtask

    initial begin
        load("inc");
        repeat (2) @(posedge clk);
        #1;
        check("rst/sen", 32'(sen), 32'd1);
        check("rst/sd", 32'(sd), 32'd0);
        check("rst/rw", 32'(rb1_rw), 32'd1);
        check("rst/a", 32'(rb1_a), 32'd0);
        check("rst/d", 32'(rb1_d), 32'd0);
        check("rst/done", 32'(s1_done), 32'd0);

        run("inc", -1);
        analyze("inc");
        check("inc/frame3_hand", 32'(exp_frame[3]), 32'h0C1003);

        rst = 1'b1;
        load("w5");
        run("w5", -1);
        analyze("w5");
        check("w5/sen_127", 32'(sen_log[127]), 32'd1);
        check("w5/sen_128", 32'(sen_log[128]), 32'd0);
        check("w5/sen_148", 32'(sen_log[148]), 32'd0);
        check("w5/sen_149", 32'(sen_log[149]), 32'd1);

        rst = 1'b1;
        load("alt");
        run("alt", -1);
        analyze("alt");
        for (int c = 24; c < 28; c++)
            check($sformatf("alt/gap_sen%0d", c), 32'(sen_log[c]), 32'd1);
        check("alt/sen_28", 32'(sen_log[28]), 32'd0);

        rst = 1'b1;
        load("inc");
        run("abort", 88);
        run("restart", -1);
        analyze("restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
